// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: sink-side VGA decoder. Registers HS/VS/RGB, recovers
// beam coordinates, measures line/frame geometry, acquires timing lock and
// folds the active pixels of each locked frame into a 16-bit signature.
module vga_timing_receiver #(
    parameter int H_ACTIVE        = 1024,
    parameter int H_SYNC          = 136,
    parameter int H_BACK_PORCH    = 160,
    parameter int H_TOTAL         = 1344,
    parameter int V_ACTIVE        = 768,
    parameter int V_SYNC          = 6,
    parameter int V_BACK_PORCH    = 29,
    parameter int V_TOTAL         = 806,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic [10:0] beam_x,
    output logic [9:0]  beam_y,
    output logic        pixel_valid,
    output logic [11:0] pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic [15:0] frame_sig,
    output logic        sig_valid
);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK_PORCH);
    localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK_PORCH + H_ACTIVE);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK_PORCH);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK_PORCH + V_ACTIVE);
    localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    state_t      state;
    logic        hs_r, vs_r, hs_d, vs_d;
    logic [11:0] rgb_r;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic [15:0] sig_acc;
    logic [7:0]  match_cnt;

    logic        hs_lead, vs_lead, active;
    logic        line_bad, frame_bad, hs_lost;
    logic [11:0] h_next, line_meas;
    logic [10:0] v_next, frame_meas;
    logic [15:0] sig_next;

    // Counters are advanced one stage early (h_next/v_next) so that the
    // coordinate outputs land in the same register stage as pixel_rgb.
    always_comb begin
        hs_lead    = hs_r & ~hs_d;
        vs_lead    = vs_r & ~vs_d;
        line_meas  = h_cnt + 12'd1;
        frame_meas = v_cnt + 11'd1;
        if (hs_lead)
            h_next = '0;
        else if (h_cnt == 12'hFFF)
            h_next = h_cnt;
        else
            h_next = line_meas;
        if (vs_lead)
            v_next = '0;
        else if (hs_lead && v_cnt != 11'h7FF)
            v_next = frame_meas;
        else
            v_next = v_cnt;
        active    = (h_next >= H_START) && (h_next < H_END) &&
                    (v_next >= V_START) && (v_next < V_END);
        line_bad  = hs_lead && (line_meas != H_TOT);
        frame_bad = vs_lead && (frame_meas != V_TOT);
        hs_lost   = !hs_lead && (h_cnt == 12'hFFE);
        sig_next  = active ? ({sig_acc[14:0], sig_acc[15]} ^ {4'h0, rgb_r}) : sig_acc;
    end

    // Input capture with sync polarity normalised to active-high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_r <= '0;
        end else begin
            hs_r  <= (SYNC_ACTIVE_LOW != 0) ? ~vga_hs : vga_hs;
            vs_r  <= (SYNC_ACTIVE_LOW != 0) ? ~vga_vs : vga_vs;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            rgb_r <= {vga_r, vga_g, vga_b};
        end
    end

    // Beam counters and line/frame length measurement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            if (hs_lead)
                line_len <= line_meas;
            if (vs_lead)
                frame_lines <= frame_meas;
        end
    end

    // Pixel-aligned coordinate, colour and frame-start outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beam_x      <= '0;
            beam_y      <= '0;
            pixel_rgb   <= '0;
            frame_start <= 1'b0;
        end else begin
            beam_x      <= active ? 11'(h_next - H_START) : '0;
            beam_y      <= active ? 10'(v_next - V_START) : '0;
            pixel_rgb   <= rgb_r;
            frame_start <= vs_lead;
        end
    end

    // Frame signature; published only for frames that were fully locked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_acc   <= '0;
            frame_sig <= '0;
            sig_valid <= 1'b0;
        end else begin
            sig_acc   <= vs_lead ? '0 : sig_next;
            sig_valid <= vs_lead && (state == LOCKED);
            if (vs_lead && (state == LOCKED))
                frame_sig <= sig_next;
        end
    end

    // Lock FSM with registered locked/timing_error/pixel_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
            pixel_valid  <= 1'b0;
        end else begin
            timing_error <= 1'b0;
            pixel_valid  <= 1'b0;
            case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vs_lead) begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (line_bad || frame_bad) begin
                        state <= SEARCH;
                    end else if (vs_lead) begin
                        if (LOCK_N <= 8'd1) begin
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            pixel_valid <= active;
                        end else begin
                            state     <= VERIFY;
                            match_cnt <= 8'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (line_bad || frame_bad) begin
                        state <= SEARCH;
                    end else if (vs_lead) begin
                        match_cnt <= match_cnt + 8'd1;
                        if (match_cnt + 8'd1 >= LOCK_N) begin
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            pixel_valid <= active;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad || hs_lost) begin
                        state        <= SEARCH;
                        locked       <= 1'b0;
                        timing_error <= 1'b1;
                    end else begin
                        pixel_valid <= active;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver: drives a scaled-down VGA raster into an active-low
// and an active-high sync instance and compares both against a line/frame
// level reference model, plus table-driven scenario summaries.
module tb_vga_timing_receiver;

    localparam int HA = 8, HSY = 2, HBP = 3, HT = 16;
    localparam int VA = 4, VSY = 1, VBP = 2, VT = 10;
    localparam int LF = 2;
    localparam int XOFF = HSY + HBP;
    localparam int YOFF = VSY + VBP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_in = 1'b0, vs_in = 1'b0;
    logic [3:0] r_in = '0, g_in = '0, b_in = '0;

    always #5 clk = ~clk;

    logic [10:0] bx_n, bx_p;
    logic [9:0]  by_n, by_p;
    logic        pv_n, pv_p, fs_n, fs_p, lk_n, lk_p, te_n, te_p, sv_n, sv_p;
    logic [11:0] rgb_n, rgb_p, ll_n, ll_p;
    logic [10:0] fl_n, fl_p;
    logic [15:0] sig_n, sig_p;
    logic [76:0] obs_n, obs_p;

    assign obs_n = {bx_n, by_n, pv_n, rgb_n, fs_n, lk_n, te_n, ll_n, fl_n, sig_n, sv_n};
    assign obs_p = {bx_p, by_p, pv_p, rgb_p, fs_p, lk_p, te_p, ll_p, fl_p, sig_p, sv_p};

    vga_timing_receiver #(
        .H_ACTIVE(HA), .H_SYNC(HSY), .H_BACK_PORCH(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VSY), .V_BACK_PORCH(VBP), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LF)
    ) dut_n (
        .clk(clk), .rst(rst), .vga_hs(~hs_in), .vga_vs(~vs_in),
        .vga_r(r_in), .vga_g(g_in), .vga_b(b_in),
        .beam_x(bx_n), .beam_y(by_n), .pixel_valid(pv_n), .pixel_rgb(rgb_n),
        .frame_start(fs_n), .locked(lk_n), .timing_error(te_n),
        .line_len(ll_n), .frame_lines(fl_n), .frame_sig(sig_n), .sig_valid(sv_n)
    );

    vga_timing_receiver #(
        .H_ACTIVE(HA), .H_SYNC(HSY), .H_BACK_PORCH(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VSY), .V_BACK_PORCH(VBP), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(LF)
    ) dut_p (
        .clk(clk), .rst(rst), .vga_hs(hs_in), .vga_vs(vs_in),
        .vga_r(r_in), .vga_g(g_in), .vga_b(b_in),
        .beam_x(bx_p), .beam_y(by_p), .pixel_valid(pv_p), .pixel_rgb(rgb_p),
        .frame_start(fs_p), .locked(lk_p), .timing_error(te_p),
        .line_len(ll_p), .frame_lines(fl_p), .frame_sig(sig_p), .sig_valid(sv_p)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model state: clocks since the last HS edge, lines since the
    // last VS edge, and the number of VS edges seen since the last fault
    int          m_h, m_v, m_since, m_ll, m_fl;
    logic        m_phs, m_pvs;
    logic [15:0] m_sig, m_fsig;
    logic [76:0] pend;

    int  cnt_sv, cnt_err, cnt_fs, cnt_valid;
    bit  scan_mode = 1'b0;

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [76:0] got, input logic [76:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // One pixel through the spec rules; returns the expected output word.
    task automatic model_pixel(input logic hs, input logic vs, input logic [11:0] rgb,
                               output logic [76:0] e);
        logic hl, vl, was_locked, fault, terr, lk, act, sv;
        int nh, nv, lm, fm;
        logic [15:0] step_sig;
        hl = hs && !m_phs;
        vl = vs && !m_pvs;
        m_phs = hs;
        m_pvs = vs;
        was_locked = (m_since >= 1 + LF);
        lm = (m_h + 1) % 4096;
        fm = (m_v + 1) % 2048;
        nh = hl ? 0 : ((m_h >= 4095) ? 4095 : m_h + 1);
        nv = vl ? 0 : (hl ? ((m_v >= 2047) ? 2047 : m_v + 1) : m_v);
        fault = (m_since >= 1) &&
                ((hl && lm != HT) || (vl && fm != VT) ||
                 (was_locked && !hl && nh == 4095 && m_h != 4095));
        terr = fault && was_locked;
        if (fault) m_since = 0;
        else if (vl && m_since < 100) m_since++;
        lk = (m_since >= 1 + LF);
        act = (nh >= XOFF) && (nh < XOFF + HA) && (nv >= YOFF) && (nv < YOFF + VA);
        step_sig = act ? ({m_sig[14:0], m_sig[15]} ^ {4'h0, rgb}) : m_sig;
        sv = vl && was_locked;
        if (sv) m_fsig = step_sig;
        m_sig = vl ? 16'h0 : step_sig;
        if (hl) m_ll = lm;
        if (vl) m_fl = fm;
        m_h = nh;
        m_v = nv;
        e = {act ? 11'(nh - XOFF) : 11'd0, act ? 10'(nv - YOFF) : 10'd0, act && lk, rgb,
             vl, lk, terr, 12'(m_ll), 11'(m_fl), m_fsig, sv};
    endtask

    task automatic step(input logic hs, input logic vs, input logic [11:0] rgb);
        logic [76:0] e;
        hs_in = hs;
        vs_in = vs;
        {r_in, g_in, b_in} = rgb;
        @(posedge clk);
        #1;
        cyc++;
        chk_vec("pixel_n", obs_n, pend);
        chk_vec("pixel_p", obs_p, pend);
        if (scan_mode && pv_n)
            chk_int("scan_rgb", int'(rgb_n), (int'(bx_n) + XOFF) % 4096);
        cnt_sv    += int'(sv_n);
        cnt_err   += int'(te_n);
        cnt_fs    += int'(fs_n);
        cnt_valid += int'(pv_n);
        model_pixel(hs, vs, rgb, e);
        pend = e;
    endtask

    task automatic do_reset();
        logic [76:0] e;
        rst = 1'b0;
        #1;
        chk_vec("async_reset_n", obs_n, '0);
        chk_vec("async_reset_p", obs_p, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_h = 0; m_v = 0; m_since = 0; m_ll = 0; m_fl = 0;
        m_phs = 1'b0; m_pvs = 1'b0; m_sig = '0; m_fsig = '0;
        cnt_sv = 0; cnt_err = 0; cnt_fs = 0; cnt_valid = 0;
        // the reset contents of the input register are clocked through once
        model_pixel(1'b0, 1'b0, 12'h0, e);
        pend = e;
    endtask

    // drives pixel indices [first,last) of one frame (last<0: whole frame)
    task automatic gen_frame(input int lines, input int sl, input int slen,
                             input int first, input int last);
        int p;
        int len;
        p = 0;
        for (int y = 0; y < lines; y++) begin
            len = (y == sl) ? slen : HT;
            for (int x = 0; x < len; x++) begin
                if (p >= first && (last < 0 || p < last))
                    step(x < HSY, y < VSY, scan_mode ? 12'(x) : 12'($urandom));
                p++;
            end
        end
    endtask

    typedef struct {
        int frames; int vlines; int sframe; int sidx; int slen; bit scan;
        int e_locked; int e_ll; int e_fl; int e_sv; int e_err; int e_fs; int e_valid;
    } rec_t;

    rec_t recs[4];

    initial begin
        // nominal, wrong height, line glitch while locked, coordinate scan
        recs[0] = '{4, VT,     -1, -1, HT,     1'b0, 1, HT, VT,     2, 0, 5, 2 * HA * VA};
        recs[1] = '{4, VT - 1, -1, -1, HT,     1'b0, 0, HT, VT - 1, 0, 0, 5, 0};
        recs[2] = '{6, VT,      3,  5, HT - 1, 1'b0, 1, HT, VT,     1, 1, 7, HA * VA + 3 * HA};
        recs[3] = '{4, VT,     -1, -1, HT,     1'b1, 1, HT, VT,     2, 0, 5, 2 * HA * VA};

        #2;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            scan_mode = recs[i].scan;
            for (int f = 0; f < recs[i].frames; f++)
                gen_frame(recs[i].vlines, (f == recs[i].sframe) ? recs[i].sidx : -1,
                          recs[i].slen, 0, -1);
            gen_frame(VT, -1, HT, 0, 2);
            chk_int($sformatf("rec%0d_locked", i), int'(lk_n), recs[i].e_locked);
            chk_int($sformatf("rec%0d_line_len", i), int'(ll_n), recs[i].e_ll);
            chk_int($sformatf("rec%0d_frame_lines", i), int'(fl_n), recs[i].e_fl);
            chk_int($sformatf("rec%0d_sig_valid_cnt", i), cnt_sv, recs[i].e_sv);
            chk_int($sformatf("rec%0d_error_cnt", i), cnt_err, recs[i].e_err);
            chk_int($sformatf("rec%0d_frame_start_cnt", i), cnt_fs, recs[i].e_fs);
            chk_int($sformatf("rec%0d_valid_cnt", i), cnt_valid, recs[i].e_valid);
        end
        scan_mode = 1'b0;

        // lost HS while locked: one HS pulse, then 5000 clocks with no HS
        do_reset();
        for (int f = 0; f < 3; f++) gen_frame(VT, -1, HT, 0, -1);
        gen_frame(VT, -1, HT, 0, 2 * HT);
        for (int x = 0; x < HSY + 5000; x++) step(x < HSY, 1'b0, 12'($urandom));
        chk_int("lost_hs_error_cnt", cnt_err, 1);
        chk_int("lost_hs_unlocked", int'(lk_n), 0);
        for (int f = 0; f < 4; f++) gen_frame(VT, -1, HT, 0, -1);
        gen_frame(VT, -1, HT, 0, 2);
        chk_int("lost_hs_relocked", int'(lk_n), 1);
        chk_int("lost_hs_sig_valid_cnt", cnt_sv, 3);

        // async reset mid-line while locked, then resume the same raster
        do_reset();
        for (int f = 0; f < 3; f++) gen_frame(VT, -1, HT, 0, -1);
        gen_frame(VT, -1, HT, 0, 3 * HT + 7);
        chk_int("pre_reset_locked", int'(lk_n), 1);
        do_reset();
        gen_frame(VT, -1, HT, 3 * HT + 7, -1);
        gen_frame(VT, -1, HT, 0, -1);
        gen_frame(VT, -1, HT, 0, -1);
        chk_int("post_reset_not_yet_locked", int'(lk_n), 0);
        gen_frame(VT, -1, HT, 0, -1);
        gen_frame(VT, -1, HT, 0, 2);
        chk_int("post_reset_relocked", int'(lk_n), 1);
        chk_int("post_reset_sig_valid_cnt", cnt_sv, 1);
        chk_int("post_reset_error_cnt", cnt_err, 0);

        // randomized geometry and colour against the model
        do_reset();
        for (int f = 0; f < 24; f++) begin
            int vl, sl, slen, pick;
            pick = int'($urandom_range(0, 7));
            vl = (pick == 0) ? VT - 1 : ((pick == 1) ? VT + 1 : VT);
            sl = -1;
            slen = HT;
            if ($urandom_range(0, 4) == 0) begin
                sl = int'($urandom_range(0, vl - 1));
                slen = ($urandom_range(0, 1) == 1) ? HT + 1 : HT - 1;
            end
            gen_frame(vl, sl, slen, 0, -1);
        end
        gen_frame(VT, -1, HT, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
